// File: rtl/uart_fifo.sv
// Memory-mapped UART with TX/RX byte FIFOs, sticky error flags and a registered interrupt.
// Register map on uart_addr[3:2]: DATA, STATUS, CTRL, reserved.
module uart_fifo #(
    parameter int unsigned clk_divider_bit = 10,
    parameter int unsigned fifo_depth      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_valid,
    input  logic        uart_instr,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        uart_irq
);
    localparam int unsigned AW   = $clog2(fifo_depth);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned DW   = $clog2(clk_divider_bit);
    localparam int unsigned HALF = clk_divider_bit / 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [31:0]   r_rdata;
    logic          r_ready, r_tx, r_irq;
    logic [1:0]    r_ctrl;
    logic          r_rx_ovf, r_tx_ovf, r_frame_err;
    logic          r_rx_s1, r_rx_s2;

    logic [7:0]    r_txf_mem [fifo_depth];
    logic [AW-1:0] r_txf_wp, r_txf_rp;
    logic [CW-1:0] r_txf_cnt;
    logic [7:0]    r_rxf_mem [fifo_depth];
    logic [AW-1:0] r_rxf_wp, r_rxf_rp;
    logic [CW-1:0] r_rxf_cnt;

    logic [1:0]    r_tx_state, r_rx_state;
    logic [DW-1:0] r_tx_cnt, r_rx_cnt;
    logic [2:0]    r_tx_bit, r_rx_bit;
    logic [7:0]    r_tx_shift, r_rx_shift;

    logic [1:0]    w_tx_state_nxt, w_rx_state_nxt;
    logic [DW-1:0] w_tx_cnt_nxt, w_rx_cnt_nxt;
    logic [2:0]    w_tx_bit_nxt, w_rx_bit_nxt;
    logic [7:0]    w_tx_shift_nxt, w_rx_shift_nxt;
    logic          w_tx_out_nxt, w_tx_pop, w_rx_push_req, w_ferr_set;
    logic [31:0]   w_rdata, w_status;

    wire w_unused = ^{uart_instr, uart_addr[31:4], uart_addr[1:0], uart_wdata[31:8]};

    wire [1:0] w_sel      = uart_addr[3:2];
    wire       w_wr       = uart_valid && (uart_wstrb != 4'h0);
    wire       w_rd       = uart_valid && (uart_wstrb == 4'h0);
    wire       w_rx       = r_rx_s2;
    wire       w_tx_busy  = (r_tx_state != S_IDLE);
    wire       w_tx_empty = (r_txf_cnt == CW'(0));
    wire       w_tx_full  = (r_txf_cnt == CW'(fifo_depth));
    wire       w_rx_empty = (r_rxf_cnt == CW'(0));
    wire       w_rx_full  = (r_rxf_cnt == CW'(fifo_depth));

    wire w_tx_push_req = w_wr && (w_sel == 2'd0) && uart_wstrb[0];
    wire w_tx_push     = w_tx_push_req && !w_tx_full;
    wire w_tx_ovf_set  = w_tx_push_req && w_tx_full;
    wire w_rx_pop      = w_rd && (w_sel == 2'd0) && !w_rx_empty;
    wire w_rx_push     = w_rx_push_req && !w_rx_full;
    wire w_rx_ovf_set  = w_rx_push_req && w_rx_full;
    wire w_st_clr      = w_wr && (w_sel == 2'd1) && uart_wstrb[0];
    wire w_ctrl_wr     = w_wr && (w_sel == 2'd2) && uart_wstrb[0];

    assign w_status = {24'h0, w_tx_busy, r_frame_err, r_tx_ovf, r_rx_ovf,
                       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};

    // Read mux sees pre-cycle state; an empty DATA read returns zero.
    always_comb begin
        w_rdata = 32'h0;
        case (w_sel)
            2'd0:    w_rdata = w_rx_empty ? 32'h0 : {24'h0, r_rxf_mem[r_rxf_rp]};
            2'd1:    w_rdata = w_status;
            2'd2:    w_rdata = {30'h0, r_ctrl};
            default: w_rdata = 32'h0;
        endcase
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + DW'(1);
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_out_nxt   = r_tx;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                w_tx_out_nxt = 1'b1;
                w_tx_cnt_nxt = DW'(0);
                if (!w_tx_empty) begin
                    w_tx_pop       = 1'b1;
                    w_tx_shift_nxt = r_txf_mem[r_txf_rp];
                    w_tx_state_nxt = S_START;
                    w_tx_out_nxt   = 1'b0;
                end
            end
            S_START: if (r_tx_cnt == DW'(clk_divider_bit - 1)) begin
                w_tx_cnt_nxt   = DW'(0);
                w_tx_bit_nxt   = 3'd0;
                w_tx_state_nxt = S_DATA;
                w_tx_out_nxt   = r_tx_shift[0];
            end
            S_DATA: if (r_tx_cnt == DW'(clk_divider_bit - 1)) begin
                w_tx_cnt_nxt = DW'(0);
                if (r_tx_bit == 3'd7) begin
                    w_tx_state_nxt = S_STOP;
                    w_tx_out_nxt   = 1'b1;
                end else begin
                    w_tx_bit_nxt   = r_tx_bit + 3'd1;
                    w_tx_shift_nxt = r_tx_shift >> 1;
                    w_tx_out_nxt   = r_tx_shift[1];
                end
            end
            default: if (r_tx_cnt == DW'(clk_divider_bit - 1)) begin
                w_tx_cnt_nxt   = DW'(0);
                w_tx_state_nxt = S_IDLE;
            end
        endcase
    end

    // Receiver: mid-start glitch check, then one sample per bit period.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + DW'(1);
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_push_req  = 1'b0;
        w_ferr_set     = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                w_rx_cnt_nxt = DW'(0);
                if (!w_rx) w_rx_state_nxt = S_START;
            end
            S_START: if (r_rx_cnt == DW'(HALF - 1)) begin
                w_rx_cnt_nxt   = DW'(0);
                w_rx_bit_nxt   = 3'd0;
                w_rx_state_nxt = w_rx ? S_IDLE : S_DATA;
            end
            S_DATA: if (r_rx_cnt == DW'(clk_divider_bit - 1)) begin
                w_rx_cnt_nxt   = DW'(0);
                w_rx_shift_nxt = {w_rx, r_rx_shift[7:1]};
                if (r_rx_bit == 3'd7) w_rx_state_nxt = S_STOP;
                else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
            end
            default: if (r_rx_cnt == DW'(clk_divider_bit - 1)) begin
                w_rx_cnt_nxt   = DW'(0);
                w_rx_state_nxt = S_IDLE;
                w_rx_push_req  = w_rx;
                w_ferr_set     = !w_rx;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_txf_mem[r_txf_wp] <= uart_wdata[7:0];
        if (w_rx_push) r_rxf_mem[r_rxf_wp] <= r_rx_shift;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata     <= 32'h0;
            r_ready     <= 1'b0;
            r_tx        <= 1'b1;
            r_irq       <= 1'b0;
            r_ctrl      <= 2'b00;
            r_rx_ovf    <= 1'b0;
            r_tx_ovf    <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_txf_wp    <= AW'(0);
            r_txf_rp    <= AW'(0);
            r_txf_cnt   <= CW'(0);
            r_rxf_wp    <= AW'(0);
            r_rxf_rp    <= AW'(0);
            r_rxf_cnt   <= CW'(0);
            r_tx_state  <= S_IDLE;
            r_tx_cnt    <= DW'(0);
            r_tx_bit    <= 3'd0;
            r_tx_shift  <= 8'h0;
            r_rx_state  <= S_IDLE;
            r_rx_cnt    <= DW'(0);
            r_rx_bit    <= 3'd0;
            r_rx_shift  <= 8'h0;
        end else begin
            r_ready     <= uart_valid;
            r_rdata     <= w_rd ? w_rdata : 32'h0;
            r_tx        <= w_tx_out_nxt;
            r_irq       <= (r_ctrl[0] & !w_rx_empty) | (r_ctrl[1] & w_tx_empty & !w_tx_busy);
            if (w_ctrl_wr) r_ctrl <= uart_wdata[1:0];
            // Same-cycle set wins over a W1C clear.
            r_rx_ovf    <= w_rx_ovf_set | (r_rx_ovf    & !(w_st_clr & uart_wdata[4]));
            r_tx_ovf    <= w_tx_ovf_set | (r_tx_ovf    & !(w_st_clr & uart_wdata[5]));
            r_frame_err <= w_ferr_set   | (r_frame_err & !(w_st_clr & uart_wdata[6]));
            r_rx_s1     <= uart_rx;
            r_rx_s2     <= r_rx_s1;
            if (w_tx_push) r_txf_wp <= r_txf_wp + AW'(1);
            if (w_tx_pop)  r_txf_rp <= r_txf_rp + AW'(1);
            if (w_tx_push && !w_tx_pop)      r_txf_cnt <= r_txf_cnt + CW'(1);
            else if (w_tx_pop && !w_tx_push) r_txf_cnt <= r_txf_cnt - CW'(1);
            if (w_rx_push) r_rxf_wp <= r_rxf_wp + AW'(1);
            if (w_rx_pop)  r_rxf_rp <= r_rxf_rp + AW'(1);
            if (w_rx_push && !w_rx_pop)      r_rxf_cnt <= r_rxf_cnt + CW'(1);
            else if (w_rx_pop && !w_rx_push) r_rxf_cnt <= r_rxf_cnt - CW'(1);
            r_tx_state  <= w_tx_state_nxt;
            r_tx_cnt    <= w_tx_cnt_nxt;
            r_tx_bit    <= w_tx_bit_nxt;
            r_tx_shift  <= w_tx_shift_nxt;
            r_rx_state  <= w_rx_state_nxt;
            r_rx_cnt    <= w_rx_cnt_nxt;
            r_rx_bit    <= w_rx_bit_nxt;
            r_rx_shift  <= w_rx_shift_nxt;
        end
    end

    assign uart_rdata = r_rdata;
    assign uart_ready = r_ready;
    assign uart_tx    = r_tx;
    assign uart_irq   = r_irq;
endmodule
